// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: MEM-stage load/store to req/gnt/rvalid data bus bridge.
// Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
module dmem_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_m_i,
  input  logic [3:0]        dmem_type_m_i,
  input  logic [31:0]       addr_m_i,
  input  logic [31:0]       wdata_m_i,
  output logic              stall_m_o,
  output logic [31:0]       rdata_m_o,
  output logic              rdata_valid_m_o,
  output logic              err_m_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] T_LB  = 4'd1;
  localparam logic [3:0] T_LH  = 4'd2;
  localparam logic [3:0] T_LW  = 4'd3;
  localparam logic [3:0] T_LBU = 4'd4;
  localparam logic [3:0] T_LHU = 4'd5;
  localparam logic [3:0] T_SB  = 4'd6;
  localparam logic [3:0] T_SH  = 4'd7;
  localparam logic [3:0] T_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_type;
  logic [1:0]        r_off;
  logic              r_load;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_valid_type;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_accept;
  logic        w_timeout;
  logic        w_run;
  logic        w_req;
  logic        w_rvalid_out;

  // Lane select and sign/zero extension of the returned word
  function automatic logic [31:0] f_extend(
    input logic [31:0] d,
    input logic [3:0]  t,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    unique case (1'b1)
      (t == T_LB):  f_extend = {{24{b[7]}}, b};
      (t == T_LBU): f_extend = {24'h0, b};
      (t == T_LH):  f_extend = {{16{h[15]}}, h};
      (t == T_LHU): f_extend = {16'h0, h};
      default:      f_extend = d;
    endcase
  endfunction

  // Decode access size and direction of the incoming op
  always_comb begin
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    unique case (1'b1)
      (dmem_type_m_i == T_LB),
      (dmem_type_m_i == T_LBU): begin
        w_is_byte = 1'b1;
        w_is_load = 1'b1;
      end
      (dmem_type_m_i == T_LH),
      (dmem_type_m_i == T_LHU): begin
        w_is_half = 1'b1;
        w_is_load = 1'b1;
      end
      (dmem_type_m_i == T_LW): begin
        w_is_word = 1'b1;
        w_is_load = 1'b1;
      end
      (dmem_type_m_i == T_SB): begin
        w_is_byte  = 1'b1;
        w_is_store = 1'b1;
      end
      (dmem_type_m_i == T_SH): begin
        w_is_half  = 1'b1;
        w_is_store = 1'b1;
      end
      (dmem_type_m_i == T_SW): begin
        w_is_word  = 1'b1;
        w_is_store = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_valid_type = w_is_load | w_is_store;

  // Effective lane offset, byte enables and replicated store data
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (w_is_byte) begin
      w_off = addr_m_i[1:0];
      w_be  = 4'b0001 << w_off;
    end else if (w_is_half) begin
      w_off = {addr_m_i[1], 1'b0};
      w_be  = 4'b0011 << w_off;
    end
    if (w_is_store) begin
      if (w_is_byte)
        w_wdata = {4{wdata_m_i[7:0]}};
      else if (w_is_half)
        w_wdata = {2{wdata_m_i[15:0]}};
      else
        w_wdata = wdata_m_i;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (w_is_half & addr_m_i[0]) |
                      (w_is_word & (|addr_m_i[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) &
                    req_valid_m_i & w_valid_type;

  // Next-state logic and all outputs
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_misalign ? DONE : WAIT_GNT;
      end
      WAIT_GNT: begin
        if (bus_gnt_i) begin
          w_next = WAIT_RSP;
        end else if (r_cnt == CNT_MAX) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (bus_rvalid_i) begin
          w_next = DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase

    w_run        = ~reset;
    w_req        = w_run & (r_state == WAIT_GNT);
    w_rvalid_out = w_run & (r_state == DONE) &
                   r_load & ~r_err;

    stall_m_o = w_run & (w_accept |
                         (r_state == WAIT_GNT) |
                         (r_state == WAIT_RSP));
    bus_req_o   = w_req;
    bus_we_o    = w_req & r_we;
    bus_addr_o  = w_req ? r_addr : '0;
    bus_be_o    = w_req ? r_be : 4'h0;
    bus_wdata_o = w_req ? r_wdata : 32'h0;
    rdata_valid_m_o = w_rvalid_out;
    rdata_m_o       = w_rvalid_out ? r_rdata : 32'h0;
    err_m_o = w_run & (r_state == DONE) & r_err;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Wait-cycle counter, restarted on accept and on grant
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_accept | ((r_state == WAIT_GNT) & bus_gnt_i))
      r_cnt <= '0;
    else if ((r_state == WAIT_GNT) | (r_state == WAIT_RSP))
      r_cnt <= r_cnt + 1'b1;
  end

  // Request capture and response/error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_type  <= 4'h0;
      r_off   <= 2'b00;
      r_load  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_type  <= dmem_type_m_i;
        r_off   <= w_off;
        r_load  <= w_is_load;
        r_we    <= w_is_store;
        r_addr  <= {addr_m_i[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_err   <= w_misalign;
        r_rdata <= 32'h0;
      end
      if (w_timeout)
        r_err <= 1'b1;
      if ((r_state == WAIT_RSP) & bus_rvalid_i) begin
        r_err   <= bus_err_i;
        r_rdata <= f_extend(bus_rdata_i, r_type, r_off);
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed self-checking bench for dmem_bus_bridge.
// Checks lanes, extension, latency, timeouts, bus error and reset abort.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_m_i;
  logic [3:0]  dmem_type_m_i;
  logic [31:0] addr_m_i;
  logic [31:0] wdata_m_i;
  logic        stall_m_o;
  logic [31:0] rdata_m_o;
  logic        rdata_valid_m_o;
  logic        err_m_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  int          o_stalls;
  int          o_req_cycles;
  int          o_rv_cnt;
  int          o_rv_cycle;
  int          o_err_cnt;
  int          o_err_cycle;
  int          o_unstable;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic        o_we;
  logic [31:0] o_wdata;
  logic [31:0] o_rdata;

  always #5 clk = ~clk;

  dmem_bus_bridge #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_m_i(req_valid_m_i),
    .dmem_type_m_i(dmem_type_m_i),
    .addr_m_i(addr_m_i),
    .wdata_m_i(wdata_m_i),
    .stall_m_o(stall_m_o),
    .rdata_m_o(rdata_m_o),
    .rdata_valid_m_o(rdata_valid_m_o),
    .err_m_o(err_m_o),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i)
  );

  task automatic set_idle();
    req_valid_m_i = 1'b0;
    dmem_type_m_i = 4'h0;
    addr_m_i      = 32'h0;
    wdata_m_i     = 32'h0;
    bus_gnt_i     = 1'b0;
    bus_rvalid_i  = 1'b0;
    bus_rdata_i   = 32'h0;
    bus_err_i     = 1'b0;
  endtask

  // Issue one op at cycle 0; gnt at 1+gw; rvalid rw cycles after gnt+1.
  task automatic run_txn(
    input logic [3:0]  t,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input logic        e,
    input int          gw,
    input int          rw,
    input int          ncyc
  );
    int g;
    int r;
    g = 1 + gw;
    r = g + 1 + rw;
    o_stalls = 0; o_req_cycles = 0; o_unstable = 0;
    o_rv_cnt = 0; o_rv_cycle = -1;
    o_err_cnt = 0; o_err_cycle = -1;
    o_addr = 32'h0; o_be = 4'h0; o_we = 1'b0;
    o_wdata = 32'h0; o_rdata = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      req_valid_m_i = (c == 0);
      dmem_type_m_i = t;
      addr_m_i      = a;
      wdata_m_i     = wd;
      bus_gnt_i     = (c == g);
      bus_rvalid_i  = (c == r);
      bus_rdata_i   = (c == r) ? rd : 32'h0;
      bus_err_i     = (c == r) ? e : 1'b0;
      #1;
      if (stall_m_o) o_stalls++;
      if (bus_req_o) begin
        if (o_req_cycles > 0 &&
            (bus_addr_o !== o_addr || bus_be_o !== o_be ||
             bus_we_o !== o_we || bus_wdata_o !== o_wdata))
          o_unstable++;
        o_req_cycles++;
        o_addr  = bus_addr_o;
        o_be    = bus_be_o;
        o_we    = bus_we_o;
        o_wdata = bus_wdata_o;
      end
      if (rdata_valid_m_o) begin
        o_rv_cnt++;
        o_rv_cycle = c;
        o_rdata    = rdata_m_o;
      end
      if (err_m_o) begin
        o_err_cnt++;
        o_err_cycle = c;
      end
    end
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    req_valid_m_i = 1'b1;
    dmem_type_m_i = 4'd8;
    addr_m_i      = 32'h1000_0004;
    #1;
    n_tests++;
    if ({stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_during got=%b exp=0000",
               {stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o});
    end
    @(negedge clk);
    set_idle();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({stall_m_o, bus_req_o, bus_we_o, rdata_valid_m_o, err_m_o} !== 5'b0 ||
        bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 ||
        bus_wdata_o !== 32'h0 || rdata_m_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_idle got stall=%b req=%b addr=%h be=%h",
               stall_m_o, bus_req_o, bus_addr_o, bus_be_o);
    end
  endtask

  task automatic test_store();
    run_txn(4'd8, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_addr !== 32'h1000_0004) begin
      n_fail++; $display("FAIL sw_addr got=%h exp=10000004", o_addr);
    end
    n_tests++;
    if (o_be !== 4'b1111 || o_we !== 1'b1) begin
      n_fail++; $display("FAIL sw_be_we got=%b/%b exp=1111/1", o_be, o_we);
    end
    n_tests++;
    if (o_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_wdata);
    end
    n_tests++;
    if (o_stalls != 3 || o_req_cycles != 1) begin
      n_fail++;
      $display("FAIL sw_stall got=%0d/%0d exp=3/1", o_stalls, o_req_cycles);
    end
    n_tests++;
    if (o_rv_cnt != 0 || o_err_cnt != 0) begin
      n_fail++;
      $display("FAIL sw_pulses got rv=%0d err=%0d exp=0/0", o_rv_cnt, o_err_cnt);
    end

    run_txn(4'd6, 32'h0000_2003, 32'h0000_00A5, 32'h0, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_be !== 4'b1000 || o_wdata !== 32'hA5A5_A5A5 ||
        o_addr !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL sb got be=%b wd=%h a=%h exp=1000/a5a5a5a5/2000",
               o_be, o_wdata, o_addr);
    end

    run_txn(4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
      n_fail++;
      $display("FAIL sh_hi got be=%b wd=%h exp=1100/abcdabcd", o_be, o_wdata);
    end
  endtask

  task automatic test_load();
    run_txn(4'd1, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'hFFFF_FF80 || o_rv_cycle != 3 || o_rv_cnt != 1) begin
      n_fail++;
      $display("FAIL lb got=%h cyc=%0d n=%0d exp=ffffff80/3/1",
               o_rdata, o_rv_cycle, o_rv_cnt);
    end
    n_tests++;
    if (o_be !== 4'b0010 || o_we !== 1'b0) begin
      n_fail++; $display("FAIL lb_be got=%b/%b exp=0010/0", o_be, o_we);
    end

    run_txn(4'd4, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0000_0080 || o_rv_cnt != 1) begin
      n_fail++; $display("FAIL lbu got=%h exp=00000080", o_rdata);
    end

    run_txn(4'd2, 32'h0000_2002, 32'h0, 32'h1234_80FF, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0000_1234 || o_be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lh got=%h be=%b exp=00001234/1100", o_rdata, o_be);
    end

    run_txn(4'd2, 32'h0000_2002, 32'h0, 32'h8001_0000, 1'b0, 2, 1, 7);
    n_tests++;
    if (o_rdata !== 32'hFFFF_8001 || o_rv_cycle != 6) begin
      n_fail++;
      $display("FAIL lh_neg got=%h cyc=%0d exp=ffff8001/6", o_rdata, o_rv_cycle);
    end
    n_tests++;
    if (o_req_cycles != 3 || o_unstable != 0 || o_stalls != 6) begin
      n_fail++;
      $display("FAIL gnt_wait got req=%0d unst=%0d stall=%0d exp=3/0/6",
               o_req_cycles, o_unstable, o_stalls);
    end

    run_txn(4'd5, 32'h0000_2000, 32'h0, 32'h0000_F00D, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0000_F00D || o_be !== 4'b0011) begin
      n_fail++;
      $display("FAIL lhu got=%h be=%b exp=0000f00d/0011", o_rdata, o_be);
    end
  endtask

  task automatic test_misalign();
    run_txn(4'd3, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 4);
`ifdef MISALIGN_TRAP_EN
    n_tests++;
    if (o_req_cycles != 0 || o_err_cnt != 1 || o_err_cycle != 1) begin
      n_fail++;
      $display("FAIL lw_trap got req=%0d err=%0d@%0d exp=0/1@1",
               o_req_cycles, o_err_cnt, o_err_cycle);
    end
    n_tests++;
    if (o_stalls != 1 || o_rv_cnt != 0) begin
      n_fail++;
      $display("FAIL lw_trap_stall got=%0d rv=%0d exp=1/0", o_stalls, o_rv_cnt);
    end
`else
    n_tests++;
    if (o_addr !== 32'h0000_3000 || o_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL lw_mis got a=%h be=%b exp=3000/1111", o_addr, o_be);
    end
    n_tests++;
    if (o_rdata !== 32'hCAFE_F00D || o_err_cnt != 0) begin
      n_fail++;
      $display("FAIL lw_mis_data got=%h err=%0d exp=cafef00d/0",
               o_rdata, o_err_cnt);
    end
    run_txn(4'd7, 32'h0000_2001, 32'h0000_5AC3, 32'h0, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_be !== 4'b0011 || o_wdata !== 32'h5AC3_5AC3 || o_err_cnt != 0) begin
      n_fail++;
      $display("FAIL sh_mis got be=%b wd=%h exp=0011/5ac35ac3", o_be, o_wdata);
    end
`endif
  endtask

  task automatic test_timeout();
    run_txn(4'd3, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 20, 0, 19);
    n_tests++;
    if (o_req_cycles != 16 || o_err_cnt != 1 || o_err_cycle != 17) begin
      n_fail++;
      $display("FAIL gnt_to got req=%0d err=%0d@%0d exp=16/1@17",
               o_req_cycles, o_err_cnt, o_err_cycle);
    end
    n_tests++;
    if (o_rv_cnt != 0 || o_stalls != 17) begin
      n_fail++;
      $display("FAIL gnt_to_rv got rv=%0d stall=%0d exp=0/17", o_rv_cnt, o_stalls);
    end

    run_txn(4'd3, 32'h0000_4008, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0BAD_CAFE || o_rv_cycle != 3 || o_err_cnt != 0) begin
      n_fail++;
      $display("FAIL after_to got=%h cyc=%0d exp=0badcafe/3", o_rdata, o_rv_cycle);
    end

    run_txn(4'd3, 32'h0000_4010, 32'h0, 32'h0, 1'b0, 0, 30, 20);
    n_tests++;
    if (o_err_cnt != 1 || o_err_cycle != 18 || o_rv_cnt != 0) begin
      n_fail++;
      $display("FAIL rsp_to got err=%0d@%0d rv=%0d exp=1@18/0",
               o_err_cnt, o_err_cycle, o_rv_cnt);
    end
  endtask

  task automatic test_bus_err();
    run_txn(4'd3, 32'h0000_5000, 32'h0, 32'h1111_2222, 1'b1, 0, 0, 4);
    n_tests++;
    if (o_err_cnt != 1 || o_err_cycle != 3 || o_rv_cnt != 0) begin
      n_fail++;
      $display("FAIL bus_err got err=%0d@%0d rv=%0d exp=1@3/0",
               o_err_cnt, o_err_cycle, o_rv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid_m_i = 1'b1;
    dmem_type_m_i = 4'd3;
    addr_m_i      = 32'h0000_6000;
    @(negedge clk);
    req_valid_m_i = 1'b0;
    bus_gnt_i     = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    #1;
    n_tests++;
    if (stall_m_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_wait_rsp got stall=%b exp=1", stall_m_o);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rst got=%b exp=0000",
               {stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o} !== 4'b0 ||
        rdata_m_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_after got=%b exp=0000",
               {stall_m_o, bus_req_o, rdata_valid_m_o, err_m_o});
    end
    @(negedge clk);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h7777_7777;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rdata_valid_m_o || err_m_o || stall_m_o) bad++;
      @(negedge clk);
      set_idle();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL late_rvalid got=%0d pulses exp=0", bad);
    end
  endtask

  task automatic test_none_type();
    int seen;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid_m_i = 1'b1;
      dmem_type_m_i = (k == 0) ? 4'd0 : 4'd12;
      addr_m_i      = 32'h0000_7000;
      #1;
      if (stall_m_o) seen++;
      @(negedge clk);
      #1;
      if (stall_m_o || bus_req_o) seen++;
    end
    set_idle();
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL none_type got=%0d activity exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(4'd1, 32'h0000_8003, 32'h0, 32'h7F00_0000, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0000_007F || o_rv_cycle != 3) begin
      n_fail++;
      $display("FAIL b2b_1 got=%h cyc=%0d exp=0000007f/3", o_rdata, o_rv_cycle);
    end
    run_txn(4'd5, 32'h0000_8002, 32'h0, 32'hBEEF_0000, 1'b0, 0, 0, 4);
    n_tests++;
    if (o_rdata !== 32'h0000_BEEF || o_rv_cycle != 3 || o_stalls != 3) begin
      n_fail++;
      $display("FAIL b2b_2 got=%h cyc=%0d st=%0d exp=0000beef/3/3",
               o_rdata, o_rv_cycle, o_stalls);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    test_none_type();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
